// File: rtl/chimp_board.sv
// chimp_board: tile board with LFSR-driven placement, press-to-clear and a registered display read port.
module chimp_board #(
  parameter int         CELLS = 40,
  parameter logic [7:0] SEED  = 8'hA5
) (
  input  logic       clk,
  input  logic       iResetn,
  input  logic       iLoadStart,
  input  logic [4:0] iLevel,
  input  logic       iPress,
  input  logic [5:0] iCell,
  input  logic [5:0] iRdCell,
  output logic [5:0] oRdNum,
  output logic [5:0] oPressNum,
  output logic       oBusy,
  output logic       oDone
);
  typedef enum logic [1:0] {IDLE, CLEAR, PLACE, READY} state_t;
  localparam logic [5:0] CN   = 6'(CELLS);
  localparam logic [5:0] LAST = 6'(CELLS - 1);
  state_t     state_q, state_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic [4:0] tot_q, tot_d, n_q, n_d;
  logic [5:0] c_q, c_d, idx_q, idx_d, press_q, press_d, rd_q, rd_d;
  logic       first_q, first_d, done_q, done_d;
  logic [5:0] board_q [CELLS];
  logic       we;
  logic [5:0] wa, wd, rnd, cand, cand_v, hit_v;
  always_comb begin
    lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    rnd     = (lfsr_q[5:0] >= CN) ? lfsr_q[5:0] - CN : lfsr_q[5:0];
    cand    = first_q ? rnd : c_q;
    cand_v  = board_q[cand];
    hit_v   = (iCell < CN) ? board_q[iCell] : 6'd0;
    rd_d    = (iRdCell < CN) ? board_q[iRdCell] : 6'd0;
    state_d = state_q;
    tot_d   = tot_q;
    n_d     = n_q;
    c_d     = c_q;
    idx_d   = idx_q;
    first_d = first_q;
    done_d  = 1'b0;
    press_d = 6'd0;
    we      = 1'b0;
    wa      = cand;
    wd      = 6'd0;
    if (iLoadStart) begin
      state_d = CLEAR;
      tot_d   = (iLevel == 5'd0) ? 5'd1 : iLevel;
      n_d     = 5'd1;
      idx_d   = 6'd0;
    end else begin
      case (state_q)
        CLEAR: begin
          we      = 1'b1;
          wa      = idx_q;
          idx_d   = idx_q + 6'd1;
          state_d = (idx_q == LAST) ? PLACE : CLEAR;
          first_d = 1'b1;
        end
        PLACE: begin
          // Occupied candidates probe linearly; a fresh random start is drawn per tile.
          if (cand_v == 6'd0) begin
            we      = 1'b1;
            wd      = {1'b0, n_q};
            n_d     = n_q + 5'd1;
            first_d = 1'b1;
            state_d = (n_q == tot_q) ? READY : PLACE;
            done_d  = (n_q == tot_q);
          end else begin
            c_d     = (cand == LAST) ? 6'd0 : cand + 6'd1;
            first_d = 1'b0;
          end
        end
        READY: begin
          we      = iPress && hit_v != 6'd0;
          wa      = iCell;
          press_d = iPress ? hit_v : 6'd0;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
      tot_q   <= 5'd1;
      n_q     <= 5'd1;
      c_q     <= 6'd0;
      idx_q   <= 6'd0;
      first_q <= 1'b1;
      done_q  <= 1'b0;
      press_q <= 6'd0;
      rd_q    <= 6'd0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      tot_q   <= tot_d;
      n_q     <= n_d;
      c_q     <= c_d;
      idx_q   <= idx_d;
      first_q <= first_d;
      done_q  <= done_d;
      press_q <= press_d;
      rd_q    <= rd_d;
    end
  end
  always_ff @(posedge clk) begin
    if (we) board_q[wa] <= wd;
  end
  assign oRdNum    = rd_q;
  assign oPressNum = press_q;
  assign oBusy     = (state_q == CLEAR) || (state_q == PLACE);
  assign oDone     = done_q;
endmodule

// File: doc/chimp_board.md
CHIMP_BOARD -- requirements
Module: chimp_board

Interface
REQ-001 Parameter CELLS, default 40: number of grid cells, indexed 0..CELLS-1 (8 columns x 5 rows).
REQ-002 Parameter SEED, default 8'hA5: LFSR reset value; SHALL be non-zero.
REQ-003 clk  input  1  rising-edge system clock.
REQ-004 iResetn  input  1  reset, asynchronous, active-low.
REQ-005 iLoadStart  input  1  single-cycle pulse: clear the board and place tiles 1..level.
REQ-006 iLevel  input  5  tile count, sampled on iLoadStart; value 0 is treated as 1.
REQ-007 iPress  input  1  single-cycle pulse: the player selected cell iCell.
REQ-008 iCell  input  6  index of the pressed cell.
REQ-009 iRdCell  input  6  display read address.
REQ-010 oRdNum  output  6  tile number at iRdCell; 0 = empty; registered, 1-cycle latency.
REQ-011 oPressNum  output  6  tile number hit by the press, held for one cycle; 0 otherwise; feeds the game control path.
REQ-012 oBusy  output  1  high during CLEAR and PLACE.
REQ-013 oDone  output  1  single-cycle pulse when placement completes.

Function
REQ-014 The board SHALL be a CELLS x 6-bit store; entry 0 = empty, 1..31 = tile number.
REQ-015 The 8-bit LFSR (x^8+x^6+x^5+x^4+1) SHALL advance every cycle in every state.
REQ-016 FSM states SHALL be IDLE, CLEAR, PLACE, READY.
REQ-017 In any state, iLoadStart SHALL latch max(iLevel,1) into tile count N, set the placement counter n=1, and enter CLEAR at the next edge.
REQ-018 CLEAR SHALL write 0 to one cell per cycle, ascending from 0, and enter PLACE after cell CELLS-1 (CELLS cycles).
REQ-019 PLACE, first cycle for each n: candidate c SHALL be LFSR[5:0], minus CELLS if that value is >= CELLS.
REQ-020 PLACE, each cycle: if cell c is empty, write n to it and increment n; otherwise set c = c+1, wrapping from CELLS-1 to 0.
REQ-021 PLACE, after the cycle that writes n=N: assert oDone for one cycle and enter READY.
REQ-022 PLACE SHALL complete within N x CELLS cycles; the N tiles SHALL occupy distinct cells.
REQ-023 READY, iPress with iCell < CELLS and cell non-zero: at the next edge, oPressNum = cell value for exactly one cycle and the cell is cleared to 0.
REQ-024 READY, iPress on an empty cell or with iCell >= CELLS: oPressNum SHALL stay 0 and the board SHALL be unchanged.
REQ-025 iPress in IDLE, CLEAR or PLACE SHALL be ignored.
REQ-026 iLoadStart and iPress in the same cycle: the load SHALL win; no oPressNum pulse.
REQ-027 oRdNum SHALL return the board entry at iRdCell one cycle later in every state, and 0 for iRdCell >= CELLS.
REQ-028 Back-to-back presses on consecutive cycles SHALL each be processed independently.

Reset
REQ-029 While iResetn = 0: state = IDLE, LFSR = SEED, N = 1, n = 1, c = 0.
REQ-030 While iResetn = 0: oPressNum = 0, oRdNum = 0, oBusy = 0, oDone = 0.
REQ-031 Board contents are not reset; software SHALL treat them as undefined until the first CLEAR completes.
REQ-032 Reset deasserted mid-CLEAR or mid-PLACE SHALL leave the block in IDLE with no oDone pulse.

Verification
REQ-033 Reset, iLoadStart with iLevel=4 -> oBusy high, then oDone pulse within 40+4x40 cycles; scanning all 40 cells via iRdCell shows exactly the values 1,2,3,4 once each and 36 zeros.
REQ-034 After the 4-tile load, press the cell holding 1 -> oPressNum=1 for one cycle, then 0; that cell now reads 0. Press the cell holding 3 -> oPressNum=3.
REQ-035 In READY, press an empty cell, then iCell=45 -> oPressNum stays 0; board unchanged.
REQ-036 iLevel=31 load -> 31 distinct non-zero cells and 9 empty cells, oDone pulses once; iLevel=0 -> exactly one tile, value 1.
REQ-037 iLoadStart during PLACE (iLevel=10 then 2) -> restarts CLEAR; final board holds only 1 and 2; exactly one oDone.
REQ-038 iLoadStart and iPress in the same cycle in READY -> no oPressNum pulse, oBusy=1 next cycle; iResetn pulsed low mid-PLACE -> IDLE, all outputs 0, no oDone.
